// File: rtl/sw_debounce_sync_pkg.sv
// rtl/sw_debounce_sync_pkg.sv - shared constants for switch conditioning and clock-divider stages
package sw_debounce_sync_pkg;

  localparam int SYS_CLK_HZ = 1_000_000;
  localparam int SW_WIDTH   = 4;

  function automatic int debounce_cycles(input int ms);
    return (SYS_CLK_HZ / 1000) * ms;
  endfunction

  localparam int SW_STABLE_CNT_1MHZ = debounce_cycles(10);

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch bit: two-flop synchronizer, qualify counter, level and edge flops
module sw_debounce_bit #(
  parameter int STABLE_CNT = 10_000,
  parameter int CNT_W      = $clog2(STABLE_CNT)
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic qual
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // High on the edge where the debounced level will flip; lets the top register sw_chg in step.
  assign qual = (s2 != db) && (cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= qual & s2;
      fall <= qual & ~s2;
      if (s2 == db) begin
        cnt <= '0;
      end else if (qual) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce_sync.sv
// rtl/sw_debounce_sync.sv - synchronize and debounce slide switches, emit level and edge pulses
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int WIDTH      = SW_WIDTH,
  parameter int STABLE_CNT = SW_STABLE_CNT_1MHZ,
  parameter int CNT_W      = $clog2(STABLE_CNT)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_chg
);

  logic [WIDTH-1:0] qual;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CNT(STABLE_CNT),
      .CNT_W     (CNT_W)
    ) u_bit (
      .clk_in(clk_in),
      .rst   (rst),
      .raw   (sw_raw[i]),
      .db    (sw_db[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .qual  (qual[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sw_chg <= 1'b0;
    end else begin
      sw_chg <= |qual;
    end
  end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb/tb_sw_debounce_sync.sv - directed vector bench for sw_debounce_sync with STABLE_CNT=4
module tb_sw_debounce_sync;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } vec_t;

  logic       clk_in;
  logic       rst;
  logic [3:0] sw_raw;
  logic [3:0] sw_db;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_chg;

  int   checks;
  int   errors;
  vec_t tbl[$];

  sw_debounce_sync #(
    .WIDTH     (4),
    .STABLE_CNT(4)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_chg (sw_chg)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [3:0] raw, input logic [3:0] db,
                     input logic [3:0] rise, input logic [3:0] fall, input logic chg);
    vec_t v;
    v.rst = r; v.raw = raw; v.db = db; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Holds raw[2] low for len cycles on top of 4'b1111 and counts bit-2 edges over the window.
  task automatic glitch(input int len, output int falls, output int rises, output int chgs);
    falls = 0; rises = 0; chgs = 0;
    sw_raw = 4'b1011;
    for (int j = 0; j < len; j++) begin
      tick();
      falls += int'(sw_fall[2]); rises += int'(sw_rise[2]); chgs += int'(sw_chg);
    end
    sw_raw = 4'b1111;
    for (int j = 0; j < 14; j++) begin
      tick();
      falls += int'(sw_fall[2]); rises += int'(sw_rise[2]); chgs += int'(sw_chg);
    end
  endtask

  initial begin
    int n, rises, falls, chgs;
    logic bad;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sw_raw = 4'b0000;

    // Reset with switches high, then release: level flips on the 6th edge with rst low.
    add(3, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(5, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1);
    add(1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    add(5, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    add(1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(5, 1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b0, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1'b1);
    add(1, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    add(5, 1'b0, 4'b1011, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    add(1, 1'b0, 4'b1011, 4'b1011, 4'b0001, 4'b0000, 1'b1);
    add(2, 1'b0, 4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst    = tbl[i].rst;
      sw_raw = tbl[i].raw;
      tick();
      chk($sformatf("vec%0d_db", i),   int'(sw_db),   int'(tbl[i].db));
      chk($sformatf("vec%0d_rise", i), int'(sw_rise), int'(tbl[i].rise));
      chk($sformatf("vec%0d_fall", i), int'(sw_fall), int'(tbl[i].fall));
      chk($sformatf("vec%0d_chg", i),  int'(sw_chg),  int'(tbl[i].chg));
    end

    // Bounce on bit 1: 2-cycle runs never reach the count, settle then qualifies once.
    sw_raw = 4'b1001;
    repeat (8) tick();
    chk("bounce_pre_db", int'(sw_db), 'h9);
    bad = 1'b0;
    for (int j = 0; j < 8; j++) begin
      sw_raw[1] = ((j % 4) < 2);
      tick();
      if (sw_db[1] || sw_rise[1] || sw_chg) bad = 1'b1;
    end
    chk("bounce_quiet", int'(bad), 0);
    sw_raw[1] = 1'b1;
    n = 0; rises = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (sw_rise[1]) begin
        rises++;
        if (n == 0) n = j;
      end
    end
    chk("bounce_latency", n, 6);
    chk("bounce_rises", rises, 1);
    chk("bounce_db", int'(sw_db), 'hb);

    // Glitch just below and at the qualification length on bit 2.
    sw_raw = 4'b1111;
    repeat (8) tick();
    chk("glitch_pre_db", int'(sw_db), 'hf);
    glitch(3, falls, rises, chgs);
    chk("glitch3_falls", falls, 0);
    chk("glitch3_chg", chgs, 0);
    chk("glitch3_db", int'(sw_db), 'hf);
    glitch(4, falls, rises, chgs);
    chk("glitch4_falls", falls, 1);
    chk("glitch4_rises", rises, 1);
    chk("glitch4_chg", chgs, 2);
    chk("glitch4_db", int'(sw_db), 'hf);

    // Reset at count 2 of a bit-3 qualification discards the partial count.
    sw_raw = 4'b0000;
    repeat (8) tick();
    chk("rstmid_pre_db", int'(sw_db), 0);
    sw_raw = 4'b1000;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_db", int'(sw_db), 0);
    chk("rstmid_rise", int'(sw_rise), 0);
    rst = 1'b0;
    n = 0; rises = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (sw_rise[3]) begin
        rises++;
        if (n == 0) n = j;
      end
    end
    chk("rstmid_latency", n, 6);
    chk("rstmid_rises", rises, 1);
    chk("rstmid_final_db", int'(sw_db), 'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
